// File: rtl/uart_pkg.sv
// uart_pkg -- shared types, baud period table and pulse classifier for the auto-baud path.
// Rev 1.0
`default_nettype none

package uart_pkg;

  localparam int unsigned CLK_HZ = 23040000;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    MEASURE = 3'd1,
    SETTLE  = 3'd2,
    VERIFY  = 3'd3,
    LOCKED  = 3'd4,
    FAIL    = 3'd5
  } autobaud_state_t;

  // Clocks per bit for each baud code at CLK_HZ.
  localparam logic [16:0] PERIOD [0:6] = '{
    17'd100, 17'd200, 17'd400, 17'd600, 17'd1200, 17'd2400, 17'd4800
  };

  function automatic logic [2:0] classify(input logic [16:0] n);
    if (n < 17'd150)       return 3'd0;
    else if (n < 17'd300)  return 3'd1;
    else if (n < 17'd500)  return 3'd2;
    else if (n < 17'd900)  return 3'd3;
    else if (n < 17'd1800) return 3'd4;
    else if (n < 17'd3600) return 3'd5;
    else                   return 3'd6;
  endfunction

  // Ten bit times of the selected code: one full frame of idle.
  function automatic logic [16:0] settle_target(input logic [2:0] code);
    logic [16:0] p;
    p = (code > 3'd6) ? PERIOD[6] : PERIOD[code];
    return (p << 3) + (p << 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_pulse_meas.sv
// uart_pulse_meas -- saturating low-pulse width counter with glitch/overlong flags.
// Rev 1.0
`default_nettype none

module uart_pulse_meas #(
  parameter int unsigned MIN_PULSE = 50,
  parameter int unsigned MAX_PULSE = 9000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_glitch,
  output logic             o_over
);

  localparam logic [CNT_W-1:0] c_min_pulse = MIN_PULSE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] c_max_pulse = MAX_PULSE[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_start)
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (i_clr)
      cnt_d = '0;
    else if (i_en && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt    = cnt_q;
  assign o_glitch = (cnt_q < c_min_pulse);
  assign o_over   = (cnt_q > c_max_pulse);

endmodule

`default_nettype wire

// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl -- measures the first start bit, selects the baud code, gates the
// receiver line and confirms lock on a sync char. Rev 1.0
`default_nettype none

module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_CHAR = 8'h55,
  parameter int unsigned MIN_PULSE = 50,
  parameter int unsigned MAX_PULSE = 9000,
  parameter int unsigned HUNT_IDLE = 96000,
  parameter int unsigned VERIFY_TO = 2304000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  input  logic        i_relock,
  input  logic [7:0]  i_char,
  input  logic        i_finished,
  output logic        o_rx,
  output logic [15:0] o_baud,
  output logic        o_locked,
  output logic [7:0]  o_err_cnt
);

  localparam logic [16:0] c_hunt_idle = HUNT_IDLE[16:0];
  localparam logic [21:0] c_verify_to = VERIFY_TO[21:0];

  autobaud_state_t state_q, state_d;
  logic [16:0] idle_cnt_q, idle_cnt_d;
  logic [16:0] settle_cnt_q, settle_cnt_d;
  logic [21:0] vto_cnt_q, vto_cnt_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        meas_start, meas_clr, meas_en;
  logic [16:0] low_cnt;
  logic        low_glitch, low_over;

  uart_pulse_meas #(
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .CNT_W     (17)
  ) u_meas (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (meas_start),
    .i_clr    (meas_clr),
    .i_en     (meas_en),
    .o_cnt    (low_cnt),
    .o_glitch (low_glitch),
    .o_over   (low_over)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= HUNT;
      idle_cnt_q   <= '0;
      settle_cnt_q <= '0;
      vto_cnt_q    <= '0;
      code_q       <= 3'd6;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      vto_cnt_q    <= vto_cnt_d;
      code_q       <= code_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    settle_cnt_d = settle_cnt_q;
    vto_cnt_d    = vto_cnt_q;
    code_d       = code_q;
    err_cnt_d    = err_cnt_q;
    meas_start   = 1'b0;
    meas_clr     = 1'b0;
    meas_en      = 1'b0;

    unique case (state_q)
      HUNT: begin
        meas_clr = 1'b1;
        if (i_rx) begin
          if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 17'd1;
        end else begin
          idle_cnt_d = '0;
          if (idle_cnt_q >= c_hunt_idle) begin
            state_d    = MEASURE;
            meas_start = 1'b1;
            meas_clr   = 1'b0;
          end
        end
      end
      MEASURE: begin
        if (low_over) begin
          state_d = FAIL;
        end else if (!i_rx) begin
          meas_en = 1'b1;
        end else if (low_glitch) begin
          state_d = FAIL;
        end else begin
          code_d       = classify(low_cnt);
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (!i_rx) begin
          settle_cnt_d = '0;
        end else if ((settle_cnt_q + 17'd1) == settle_target(code_q)) begin
          settle_cnt_d = '0;
          vto_cnt_d    = '0;
          state_d      = VERIFY;
        end else begin
          settle_cnt_d = settle_cnt_q + 17'd1;
        end
      end
      VERIFY: begin
        // A char completing on the timeout clk still counts.
        if (i_finished) begin
          state_d = (i_char == SYNC_CHAR) ? LOCKED : FAIL;
        end else if (vto_cnt_q == c_verify_to) begin
          state_d = FAIL;
        end else begin
          vto_cnt_d = vto_cnt_q + 22'd1;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      FAIL: begin
        state_d    = HUNT;
        idle_cnt_d = '0;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: state_d = HUNT;
    endcase

    if (i_relock) begin
      state_d      = HUNT;
      idle_cnt_d   = '0;
      settle_cnt_d = '0;
      vto_cnt_d    = '0;
      code_d       = code_q;
      meas_start   = 1'b0;
      meas_en      = 1'b0;
      meas_clr     = 1'b1;
    end
  end

  always_comb begin
    o_rx      = ((state_q == VERIFY) || (state_q == LOCKED)) ? i_rx : 1'b1;
    o_locked  = (state_q == LOCKED);
    o_baud    = {13'd0, code_q};
    o_err_cnt = err_cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
// tb_uart_autobaud_ctrl -- scoreboarded directed bench for the auto-baud controller.
// Rev 1.0
`default_nettype none

module tb_uart_autobaud_ctrl;

  localparam int unsigned VTO   = 2500;
  localparam int unsigned IDLEN = 64;

  logic        clk = 1'b0;
  logic        i_rst, i_rx, i_relock, i_finished;
  logic [7:0]  i_char;
  logic        o_rx, o_locked;
  logic [15:0] o_baud;
  logic [7:0]  o_err_cnt;

  int n_total = 0;
  int n_pass  = 0;
  logic [24:0] exp_q[$];

  uart_autobaud_ctrl #(
    .SYNC_CHAR (8'h55),
    .MIN_PULSE (50),
    .MAX_PULSE (9000),
    .HUNT_IDLE (IDLEN),
    .VERIFY_TO (VTO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .i_relock   (i_relock),
    .i_char     (i_char),
    .i_finished (i_finished),
    .o_rx       (o_rx),
    .o_baud     (o_baud),
    .o_locked   (o_locked),
    .o_err_cnt  (o_err_cnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [24:0] tup(input logic l, input logic [2:0] c, input logic [7:0] e);
    return {l, 13'd0, c, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every change of {locked, baud, err} must match the next queued expectation.
  initial begin : monitor
    logic [24:0] prev, cur, exp;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {o_locked, o_baud, o_err_cnt};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got 0x%0h expected no change", cur);
        end else begin
          exp = exp_q.pop_front();
          check("sb_state", cur, exp);
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #(150000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int p);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx = bits[i];
      repeat (p) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_finished(input logic [7:0] c, input logic exp_lock);
    i_char = c;
    i_finished = 1'b1;
    @(negedge clk);
    check("locked_before_fin", o_locked, 0);
    @(posedge clk); #1 i_finished = 1'b0;
    @(negedge clk);
    check("locked_after_fin", o_locked, exp_lock);
    @(posedge clk); #1;
  endtask

  // First 0x55 frame measures and settles; second frame arrives in VERIFY.
  task automatic lock_attempt(input int p, input logic [7:0] c, input logic exp_lock);
    idle(80);
    send_frame(8'h55, p);
    idle(9 * p + 5);
    send_frame(c, p);
    pulse_finished(c, exp_lock);
  endtask

  task automatic relock_from_locked();
    i_rx = 1'b0;
    @(negedge clk);
    check("rx_follow_locked", o_rx, 0);
    @(posedge clk); #1 i_relock = 1'b1;
    @(posedge clk); #1 i_relock = 1'b0;
    @(negedge clk);
    check("rx_gated_after_relock", o_rx, 1);
    check("unlocked_after_relock", o_locked, 0);
    @(posedge clk); #1 i_rx = 1'b1;
  endtask

  task automatic meas_pulse(input int n, input logic [2:0] code);
    idle(80);
    i_rx = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rx_gated_measure", o_rx, 1);
    repeat (n - 1) @(posedge clk);
    #1 i_rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("code_for_%0d", n), o_baud, {13'd0, code});
    @(posedge clk); #1 i_relock = 1'b1;
    @(posedge clk); #1 i_relock = 1'b0;
  endtask

  task automatic glitch(input int n);
    idle(70);
    i_rx = 1'b0;
    repeat (n) @(posedge clk);
    #1 i_rx = 1'b1;
    idle(3);
  endtask

  initial begin : stim
    i_rst = 1'b1; i_rx = 1'b1; i_relock = 1'b0; i_char = 8'h00; i_finished = 1'b0;
    exp_q.push_back(tup(0, 6, 0));
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_locked", o_locked, 0);
    check("reset_baud", o_baud, 16'd6);
    check("reset_err", o_err_cnt, 0);
    check("reset_rx", o_rx, 1);
    @(posedge clk); #1;

    // 115200 lock
    exp_q.push_back(tup(0, 1, 0));
    exp_q.push_back(tup(1, 1, 0));
    lock_attempt(200, 8'h55, 1'b1);
    exp_q.push_back(tup(0, 1, 0));
    relock_from_locked();

    // 230400 lock
    exp_q.push_back(tup(0, 0, 0));
    exp_q.push_back(tup(1, 0, 0));
    lock_attempt(100, 8'h55, 1'b1);
    exp_q.push_back(tup(0, 0, 0));
    relock_from_locked();

    // classifier boundaries and the 4800 bit time
    exp_q.push_back(tup(0, 1, 0)); meas_pulse(150, 3'd1);
    exp_q.push_back(tup(0, 0, 0)); meas_pulse(149, 3'd0);
    exp_q.push_back(tup(0, 6, 0)); meas_pulse(3600, 3'd6);
    exp_q.push_back(tup(0, 5, 0)); meas_pulse(3599, 3'd5);
    exp_q.push_back(tup(0, 6, 0)); meas_pulse(4800, 3'd6);

    // glitch then recovery
    exp_q.push_back(tup(0, 6, 1));
    glitch(30);
    check("err_after_glitch", o_err_cnt, 1);
    exp_q.push_back(tup(0, 0, 1));
    exp_q.push_back(tup(1, 0, 1));
    lock_attempt(100, 8'h55, 1'b1);
    exp_q.push_back(tup(0, 0, 1));
    relock_from_locked();

    // wrong confirm char
    exp_q.push_back(tup(0, 0, 2));
    lock_attempt(100, 8'h5A, 1'b0);
    idle(3);
    check("err_after_mismatch", o_err_cnt, 2);
    check("unlocked_after_mismatch", o_locked, 0);

    // verify timeout, exact cycle
    exp_q.push_back(tup(0, 0, 3));
    idle(80);
    send_frame(8'h55, 100);
    repeat (900) @(posedge clk);
    #1 i_rx = 1'b0;
    repeat (VTO) @(posedge clk);
    @(negedge clk);
    check("vto_last_verify_rx", o_rx, 0);
    check("vto_last_verify_err", o_err_cnt, 2);
    @(posedge clk);
    @(negedge clk);
    check("vto_fail_rx", o_rx, 1);
    check("vto_fail_err", o_err_cnt, 2);
    @(posedge clk);
    @(negedge clk);
    check("vto_err_inc", o_err_cnt, 3);
    @(posedge clk); #1 i_rx = 1'b1;

    // char on the timeout clk wins
    exp_q.push_back(tup(1, 0, 3));
    idle(80);
    send_frame(8'h55, 100);
    repeat (900) @(posedge clk);
    #1;
    repeat (VTO) @(posedge clk);
    #1 i_char = 8'h55; i_finished = 1'b1;
    @(posedge clk); #1 i_finished = 1'b0;
    @(negedge clk);
    check("fin_at_vto_locks", o_locked, 1);
    @(posedge clk); #1;
    exp_q.push_back(tup(0, 0, 3));
    relock_from_locked();

    // relock beats a matching char in VERIFY
    idle(80);
    send_frame(8'h55, 100);
    idle(905);
    i_char = 8'h55; i_finished = 1'b1; i_relock = 1'b1;
    @(posedge clk); #1 i_finished = 1'b0; i_relock = 1'b0;
    @(negedge clk);
    check("relock_beats_fin", o_locked, 0);
    idle(3);
    check("relock_no_err", o_err_cnt, 3);

    // reset mid-VERIFY
    exp_q.push_back(tup(0, 6, 0));
    idle(80);
    send_frame(8'h55, 100);
    idle(905);
    i_rx = 1'b0;
    @(negedge clk);
    check("rx_follow_verify", o_rx, 0);
    @(posedge clk); #1 i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_mid_rx", o_rx, 1);
    check("rst_mid_locked", o_locked, 0);
    check("rst_mid_baud", o_baud, 16'd6);
    check("rst_mid_err", o_err_cnt, 0);
    @(posedge clk); #1 i_rx = 1'b1;

    // error counter saturation
    for (int k = 1; k <= 255; k++) exp_q.push_back(tup(0, 6, k[7:0]));
    for (int k = 0; k < 260; k++) glitch(30);
    check("err_saturated", o_err_cnt, 8'hFF);

    idle(5);
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
